// File: rtl/wb_commit_unit_if.sv
// Writeback commit bundle: port A (execute, valid/ready), port B (divider), divide issue,
// two GPR read ports with pending flags, and the optional perf counters.
interface wb_commit_unit_if #(
  parameter int BITWIDTH = 32,
  parameter int REGNUM   = 32
);
  localparam int IDXW = $clog2(REGNUM);

  logic                a_valid;
  logic                a_ready;
  logic [BITWIDTH-1:0] a_data;
  logic [IDXW-1:0]     a_rd;

  logic                b_valid;
  logic [BITWIDTH-1:0] b_data;
  logic [IDXW-1:0]     b_rd;

  logic                div_issue_valid;
  logic [IDXW-1:0]     div_issue_rd;

  logic [IDXW-1:0]     rs1_addr;
  logic [IDXW-1:0]     rs2_addr;
  logic [BITWIDTH-1:0] rs1_data;
  logic [BITWIDTH-1:0] rs2_data;
  logic                rs1_pending;
  logic                rs2_pending;

  logic                wb_busy;
  logic [31:0]         perf_commit_cnt;
  logic [31:0]         perf_stall_cnt;

  modport master (
    output a_valid, a_data, a_rd, b_valid, b_data, b_rd,
           div_issue_valid, div_issue_rd, rs1_addr, rs2_addr,
    input  a_ready, rs1_data, rs2_data, rs1_pending, rs2_pending,
           wb_busy, perf_commit_cnt, perf_stall_cnt
  );

  modport slave (
    input  a_valid, a_data, a_rd, b_valid, b_data, b_rd,
           div_issue_valid, div_issue_rd, rs1_addr, rs2_addr,
    output a_ready, rs1_data, rs2_data, rs1_pending, rs2_pending,
           wb_busy, perf_commit_cnt, perf_stall_cnt
  );
endinterface

// File: rtl/wb_commit_unit.sv
// GPR file with one write port: divider results (port B) take priority over a 2-entry FIFO of
// execute results (port A); bypassed read ports and pending-write hazards. WB_COMMIT_PERF_EN adds counters.
module wb_commit_unit #(
  parameter int BITWIDTH  = 32,
  parameter int REGNUM    = 32,
  parameter int FIFODEPTH = 2
) (
  input logic             clk,
  input logic             rst_n,
  wb_commit_unit_if.slave bus
);
  localparam int IDXW = $clog2(REGNUM);

  logic [BITWIDTH-1:0] fifo_dat_q [2];
  logic [IDXW-1:0]     fifo_rd_q  [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [REGNUM-1:0]   busy_q, busy_d, b_clr, busy_live;
  logic [BITWIDTH-1:0] gpr_q [REGNUM];

  logic                push, pop, fifo_nempty, wr_en;
  logic [IDXW-1:0]     wr_rd, head_rd, tail_rd;
  logic [BITWIDTH-1:0] wr_dat;
  logic                head_live, tail_live;

  assign fifo_nempty = (cnt_q != 2'd0);
  assign bus.a_ready = (cnt_q < 2'(FIFODEPTH));
  assign push        = bus.a_valid & bus.a_ready;
  assign pop         = fifo_nempty & ~bus.b_valid;
  // Gated by rst_n so the bypass cannot leak port-B data while reset is held.
  assign wr_en       = rst_n & (bus.b_valid | fifo_nempty);
  assign head_rd     = fifo_rd_q[rd_ptr_q];
  assign tail_rd     = fifo_rd_q[~rd_ptr_q];
  assign wr_rd       = bus.b_valid ? bus.b_rd   : head_rd;
  assign wr_dat      = bus.b_valid ? bus.b_data : fifo_dat_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  assign b_clr = bus.b_valid ? (REGNUM'(1) << bus.b_rd) : '0;

  // Set is applied after clear so a same-cycle reissue keeps the register busy.
  always_comb begin
    busy_d = busy_q & ~b_clr;
    if (bus.div_issue_valid && bus.div_issue_rd != '0) begin
      busy_d[bus.div_issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_dat_q[i] <= '0;
        fifo_rd_q[i]  <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      busy_q   <= '0;
    end else begin
      if (push) begin
        fifo_dat_q[wr_ptr_q] <= bus.a_data;
        fifo_rd_q[wr_ptr_q]  <= bus.a_rd;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGNUM; i++) begin
        gpr_q[i] <= '0;
      end
    end else if (wr_en && wr_rd != '0) begin
      gpr_q[wr_rd] <= wr_dat;
    end
  end

  assign bus.rs1_data = (wr_en && bus.rs1_addr != '0 && wr_rd == bus.rs1_addr) ? wr_dat
                                                                               : gpr_q[bus.rs1_addr];
  assign bus.rs2_data = (wr_en && bus.rs2_addr != '0 && wr_rd == bus.rs2_addr) ? wr_dat
                                                                               : gpr_q[bus.rs2_addr];

  // The entry or busy bit being committed this cycle is no longer a hazard: its data is bypassed.
  assign head_live = fifo_nempty & bus.b_valid;
  assign tail_live = (cnt_q == 2'd2);
  assign busy_live = busy_q & ~b_clr;

  assign bus.rs1_pending = (bus.rs1_addr != '0) &
                           ((head_live & (head_rd == bus.rs1_addr)) |
                            (tail_live & (tail_rd == bus.rs1_addr)) |
                            busy_live[bus.rs1_addr]);
  assign bus.rs2_pending = (bus.rs2_addr != '0) &
                           ((head_live & (head_rd == bus.rs2_addr)) |
                            (tail_live & (tail_rd == bus.rs2_addr)) |
                            busy_live[bus.rs2_addr]);

  assign bus.wb_busy = fifo_nempty | (|busy_q);

`ifdef WB_COMMIT_PERF_EN
  logic [31:0] commit_cnt_q, commit_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign commit_cnt_d = commit_cnt_q + {31'd0, wr_en};
  assign stall_cnt_d  = stall_cnt_q + {31'd0, (bus.a_valid & ~bus.a_ready)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      commit_cnt_q <= commit_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.perf_commit_cnt = commit_cnt_q;
  assign bus.perf_stall_cnt  = stall_cnt_q;
`else
  assign bus.perf_commit_cnt = 32'd0;
  assign bus.perf_stall_cnt  = 32'd0;
`endif
endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: directed scenarios plus random traffic, every cycle checked against
// a queue/array reference model of the commit rules.
module tb_wb_commit_unit;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_commit_unit_if #(.BITWIDTH(32), .REGNUM(32)) bus ();

  wb_commit_unit #(.BITWIDTH(32), .REGNUM(32), .FIFODEPTH(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_reg [32];
  bit          m_busy [32];
  logic [31:0] q_dat [$];
  logic [4:0]  q_rd  [$];
  logic [31:0] m_commit;
  logic [31:0] m_stall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 32'd0;
      m_busy[i] = 1'b0;
    end
    q_dat.delete();
    q_rd.delete();
    m_commit = 32'd0;
    m_stall  = 32'd0;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] addr, input bit wr,
                                           input logic [4:0] wrd, input logic [31:0] wdat);
    if (addr == 5'd0) return 32'd0;
    if (wr && wrd == addr) return wdat;
    return m_reg[addr];
  endfunction

  function automatic logic exp_pend(input logic [4:0] addr, input bit popping,
                                    input logic bv, input logic [4:0] brd);
    if (addr == 5'd0) return 1'b0;
    for (int i = 0; i < q_rd.size(); i++) begin
      if (!(popping && i == 0) && q_rd[i] == addr) return 1'b1;
    end
    return m_busy[addr] && !(bv && brd == addr);
  endfunction

  task automatic drive_idle();
    bus.a_valid = 0; bus.a_data = 0; bus.a_rd = 0;
    bus.b_valid = 0; bus.b_data = 0; bus.b_rd = 0;
    bus.div_issue_valid = 0; bus.div_issue_rd = 0;
    bus.rs1_addr = 0; bus.rs2_addr = 0;
  endtask

  // One clock cycle: drive at the falling edge, check mid-cycle, advance the model for the next edge.
  task automatic cyc(input logic av, input logic [31:0] ad, input logic [4:0] ard,
                     input logic bv, input logic [31:0] bd, input logic [4:0] brd,
                     input logic iv, input logic [4:0] ird,
                     input logic [4:0] r1, input logic [4:0] r2, output bit acc);
    bit          ready, wr, popping, any_busy;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    @(negedge clk);
    bus.a_valid = av; bus.a_data = ad; bus.a_rd = ard;
    bus.b_valid = bv; bus.b_data = bd; bus.b_rd = brd;
    bus.div_issue_valid = iv; bus.div_issue_rd = ird;
    bus.rs1_addr = r1; bus.rs2_addr = r2;
    #1;
    ready   = (q_rd.size() < 2);
    popping = !bv && (q_rd.size() > 0);
    wr      = bv || (q_rd.size() > 0);
    wrd     = bv ? brd : (q_rd.size() > 0 ? q_rd[0] : 5'd0);
    wdat    = bv ? bd  : (q_rd.size() > 0 ? q_dat[0] : 32'd0);
    any_busy = 1'b0;
    for (int i = 0; i < 32; i++) any_busy |= m_busy[i];

    chk("a_ready", {31'd0, bus.a_ready}, {31'd0, ready});
    chk("rs1_data", bus.rs1_data, exp_read(r1, wr, wrd, wdat));
    chk("rs2_data", bus.rs2_data, exp_read(r2, wr, wrd, wdat));
    chk("rs1_pending", {31'd0, bus.rs1_pending}, {31'd0, exp_pend(r1, popping, bv, brd)});
    chk("rs2_pending", {31'd0, bus.rs2_pending}, {31'd0, exp_pend(r2, popping, bv, brd)});
    chk("wb_busy", {31'd0, bus.wb_busy}, {31'd0, (q_rd.size() > 0) || any_busy});
`ifdef WB_COMMIT_PERF_EN
    chk("perf_commit", bus.perf_commit_cnt, m_commit);
    chk("perf_stall", bus.perf_stall_cnt, m_stall);
`else
    chk("perf_commit_tied", bus.perf_commit_cnt, 32'd0);
    chk("perf_stall_tied", bus.perf_stall_cnt, 32'd0);
`endif

    acc = av && ready;
    if (wr) begin
      if (wrd != 5'd0) m_reg[wrd] = wdat;
      m_commit = m_commit + 32'd1;
    end
    if (popping) begin
      void'(q_dat.pop_front());
      void'(q_rd.pop_front());
    end
    if (acc) begin
      q_dat.push_back(ad);
      q_rd.push_back(ard);
    end
    if (av && !ready) m_stall = m_stall + 32'd1;
    if (bv) m_busy[brd] = 1'b0;
    if (iv && ird != 5'd0) m_busy[ird] = 1'b1;
  endtask

  logic [31:0] w [3];
  bit          acc;
  int          idx;
  logic        hv;
  logic [31:0] hd;
  logic [4:0]  hrd;

  initial begin
    drive_idle();
    model_reset();
    #2;
    chk("rst_a_ready", {31'd0, bus.a_ready}, 32'd1);
    chk("rst_wb_busy", {31'd0, bus.wb_busy}, 32'd0);
    chk("rst_rs1_data", bus.rs1_data, 32'd0);
    chk("rst_rs1_pending", {31'd0, bus.rs1_pending}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single A write: bypass in the commit cycle, stored afterwards.
    cyc(1, 32'h12345678, 5, 0, 0, 0, 0, 0, 5, 0, acc);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 5, 5, acc);
    chk("single_bypass", bus.rs1_data, 32'h12345678);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, acc);
    chk("single_stored", bus.rs1_data, 32'h12345678);

    // Back-pressure: B hogs the write port for 4 cycles.
    w[0] = 32'hA0A0_0001; w[1] = 32'hB1B1_0002; w[2] = 32'hC2C2_0003;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      cyc(idx < 3, (idx < 3) ? w[idx] : 32'd0, 5'(10 + idx), c < 4, $urandom, 20,
          0, 0, 5'(10 + (c % 3)), 5'(11 + (c % 2)), acc);
      if (acc) idx++;
      if (c == 3) chk("bp_accepts", idx, 2);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 10, 12, acc);
    chk("bp_order_first", bus.rs1_data, w[0]);
    chk("bp_order_last", bus.rs2_data, w[2]);

    // Same rd on A and B: B first, A overwrites on the next edge.
    cyc(1, 32'hAAAA0000, 7, 1, 32'hBBBB0000, 7, 0, 0, 7, 0, acc);
    chk("same_rd_b_first", bus.rs1_data, 32'hBBBB0000);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, acc);
    chk("same_rd_a_bypass", bus.rs1_data, 32'hAAAA0000);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, acc);
    chk("same_rd_a_final", bus.rs1_data, 32'hAAAA0000);

    // rd = 0 still pops the FIFO but never lands.
    cyc(1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0, acc);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
    chk("rd0_read", bus.rs1_data, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
    chk("rd0_popped", {31'd0, bus.wb_busy}, 32'd0);

    // Divider scoreboard: set, same-cycle clear+set, then clear.
    cyc(0, 0, 0, 0, 0, 0, 1, 9, 0, 9, acc);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, acc);
    chk("sb_pending_set", {31'd0, bus.rs2_pending}, 32'd1);
    for (int c = 0; c < 3; c++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, acc);
    cyc(0, 0, 0, 1, 32'h0D1F_0001, 9, 1, 9, 0, 9, acc);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, acc);
    chk("sb_set_wins", {31'd0, bus.rs2_pending}, 32'd1);
    cyc(0, 0, 0, 1, 32'h0D1F_0002, 9, 0, 0, 0, 9, acc);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, acc);
    chk("sb_cleared", {31'd0, bus.rs2_pending}, 32'd0);
    chk("sb_data", bus.rs2_data, 32'h0D1F_0002);

    // Async reset with a full FIFO and busy bits outstanding.
    cyc(1, 32'h3333_0000, 3, 1, 32'h4444_0000, 4, 1, 6, 0, 0, acc);
    cyc(1, 32'h5555_0000, 5, 1, 32'h4444_0001, 4, 1, 8, 0, 0, acc);
    @(posedge clk);
    #3;
    bus.a_valid = 0;
    bus.div_issue_valid = 0;
    bus.b_valid = 1; bus.b_rd = 3; bus.b_data = 32'hDEAD_BEEF;
    bus.rs1_addr = 7; bus.rs2_addr = 6;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_a_ready", {31'd0, bus.a_ready}, 32'd1);
    chk("arst_wb_busy", {31'd0, bus.wb_busy}, 32'd0);
    chk("arst_rs1_data", bus.rs1_data, 32'd0);
    chk("arst_rs2_pending", {31'd0, bus.rs2_pending}, 32'd0);
    @(posedge clk);
    #1;
    bus.rs1_addr = 3;
    #1;
    chk("arst_no_write", bus.rs1_data, 32'd0);
    @(negedge clk);
    bus.b_valid = 0;
    rst_n = 1'b1;
    for (int i = 1; i < 32; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(32 - i), acc);

    // Random traffic; a stalled A word is held until accepted.
    hv = 0; hd = 0; hrd = 0;
    for (int c = 0; c < 3000; c++) begin
      logic       bv, iv;
      logic [4:0] r1, r2;
      if (!hv) begin
        hv  = ($urandom_range(0, 9) < 6);
        hd  = $urandom;
        hrd = 5'($urandom_range(0, 7));
      end
      bv = ($urandom_range(0, 3) == 0);
      iv = ($urandom_range(0, 4) == 0);
      r1 = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 7));
      cyc(hv, hd, hrd, bv, $urandom, 5'($urandom_range(0, 7)), iv, 5'($urandom_range(0, 7)),
          r1, r2, acc);
      if (acc) hv = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
